// File: rtl/fc_layer_mac_array.sv
// Time-multiplexed fully connected layer: MAC_LANES lanes compute OUT_DIMENSION
// neurons over several passes, with bias, rounding, saturation and optional ReLU.
module fc_layer_mac_array #(
  parameter int PIX_WIDTH          = 16,
  parameter int WEIGHT_WIDTH       = 16,
  parameter int WEIGHT_FRACT_WIDTH = 10,
  parameter int IN_DIMENSION       = 256,
  parameter int OUT_DIMENSION      = 64,
  parameter int MAC_LANES          = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clk_en,
  input  logic [$clog2(IN_DIMENSION):0]     cfg_in_len,
  input  logic                              cfg_relu,
  input  logic [PIX_WIDTH-1:0]              i_data,
  input  logic                              i_valid,
  input  logic                              i_sop,
  input  logic                              i_eop,
  output logic                              i_ready,
  output logic [PIX_WIDTH-1:0]              o_data,
  output logic                              o_valid,
  output logic                              o_sop,
  output logic                              o_eop,
  input  logic                              o_ready,
  output logic                              o_err,
  input  logic                              wr_en,
  input  logic                              wr_bias,
  input  logic [$clog2(OUT_DIMENSION)-1:0]  wr_neuron,
  input  logic [$clog2(IN_DIMENSION)-1:0]   wr_index,
  input  logic [WEIGHT_WIDTH-1:0]           wr_data
);

  localparam int IDX_W  = $clog2(IN_DIMENSION);
  localparam int LEN_W  = IDX_W + 1;
  localparam int NEU_W  = $clog2(OUT_DIMENSION);
  localparam int PASSES = OUT_DIMENSION / MAC_LANES;
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int LANE_W = (MAC_LANES > 1) ? $clog2(MAC_LANES) : 1;
  localparam int DEPTH  = PASSES * IN_DIMENSION;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PROD_W = PIX_WIDTH + WEIGHT_WIDTH;
  localparam int ACC_W  = PIX_WIDTH + WEIGHT_WIDTH + IDX_W;
  localparam int SUM_W  = ACC_W + 1;

  localparam logic signed [SUM_W-1:0] RND  = SUM_W'(1) <<< (WEIGHT_FRACT_WIDTH - 1);
  localparam logic signed [SUM_W-1:0] PMAX = {{(SUM_W-PIX_WIDTH+1){1'b0}}, {(PIX_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] PMIN = ~PMAX;
  localparam logic [PASS_W-1:0]       LAST_PASS = PASS_W'(PASSES - 1);
  localparam logic [LANE_W-1:0]       LAST_BEAT = LANE_W'(MAC_LANES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, OUTPUT} state_t;

  state_t                         r_state, w_state_nxt;
  logic signed [PIX_WIDTH-1:0]    r_buf [IN_DIMENSION];
  logic signed [WEIGHT_WIDTH-1:0] r_bias [OUT_DIMENSION];
  logic [LEN_W-1:0]               r_wcnt, r_len, r_cfg_len, r_idx;
  logic                           r_relu;
  logic [PASS_W-1:0]              r_pass;
  logic [LANE_W-1:0]              r_beat;
  logic signed [PIX_WIDTH-1:0]    r_x;
  logic                           r_v1, r_v2, r_v3, r_f1, r_f2;
  logic                           r_err, w_err;
  logic                           w_post, w_wr_ok;
  logic [LEN_W-1:0]               w_cnt_nxt;
  logic [31:0]                    w_neu_ext, w_idx_ext, w_wr_lane;
  logic [ADDR_W-1:0]              w_wr_addr, w_rd_addr;
  logic [MAC_LANES-1:0][PIX_WIDTH-1:0] w_obuf;

  assign w_cnt_nxt = r_wcnt + LEN_W'(1);
  assign w_neu_ext = 32'(wr_neuron);
  assign w_idx_ext = 32'(wr_index);
  assign w_wr_lane = w_neu_ext % MAC_LANES;
  assign w_wr_addr = ADDR_W'(w_neu_ext / MAC_LANES * IN_DIMENSION + w_idx_ext);
  assign w_rd_addr = ADDR_W'(32'(r_pass) * IN_DIMENSION + 32'(r_idx));
  assign w_wr_ok   = wr_en && (r_state == IDLE || r_state == LOAD) &&
                     (w_neu_ext < OUT_DIMENSION) && (wr_bias || w_idx_ext < IN_DIMENSION);
  // Post-processing waits until the last product has been folded into every accumulator.
  assign w_post    = (r_state == DRAIN) && !(r_v1 || r_v2 || r_v3);
  assign o_err     = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else if (clk_en) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    unique case (r_state)
      IDLE: if (i_valid && i_sop) begin
        w_state_nxt = i_eop ? COMPUTE : LOAD;
        w_err       = i_eop && (cfg_in_len != LEN_W'(1));
      end
      LOAD: if (i_valid) begin
        if (i_sop) begin
          w_err = 1'b1;
          if (i_eop) w_state_nxt = COMPUTE;
        end else if (i_eop) begin
          w_state_nxt = COMPUTE;
          w_err       = (w_cnt_nxt != r_cfg_len);
        end else if (w_cnt_nxt == LEN_W'(IN_DIMENSION)) begin
          w_state_nxt = COMPUTE;
          w_err       = 1'b1;
        end
      end
      COMPUTE: if (r_idx == r_len - LEN_W'(1)) w_state_nxt = DRAIN;
      DRAIN:   if (w_post) w_state_nxt = OUTPUT;
      OUTPUT:  if (o_ready && r_beat == LAST_BEAT)
                 w_state_nxt = (r_pass == LAST_PASS) ? IDLE : COMPUTE;
      default: w_state_nxt = IDLE;
    endcase
    if (wr_en && (r_state == COMPUTE || r_state == DRAIN || r_state == OUTPUT)) w_err = 1'b1;
  end

  always_comb begin
    i_ready = (r_state == IDLE) || (r_state == LOAD);
    o_valid = (r_state == OUTPUT);
    o_sop   = o_valid && (r_pass == '0) && (r_beat == '0);
    o_eop   = o_valid && (r_pass == LAST_PASS) && (r_beat == LAST_BEAT);
    o_data  = o_valid ? w_obuf[r_beat] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt <= '0; r_len <= '0; r_cfg_len <= '0; r_relu <= 1'b0;
      r_idx  <= '0; r_pass <= '0; r_beat <= '0; r_x <= '0;
      r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0; r_f1 <= 1'b0; r_f2 <= 1'b0;
      r_err <= 1'b0;
    end else if (clk_en) begin
      r_err <= w_err;
      r_v1  <= (r_state == COMPUTE);
      r_f1  <= (r_state == COMPUTE) && (r_idx == '0);
      r_v2  <= r_v1;
      r_f2  <= r_f1;
      r_v3  <= r_v2;
      if (r_state == COMPUTE) r_x <= r_buf[r_idx[IDX_W-1:0]];
      unique case (r_state)
        IDLE: if (i_valid && i_sop) begin
          r_cfg_len <= cfg_in_len; r_relu <= cfg_relu;
          r_wcnt <= LEN_W'(1); r_len <= LEN_W'(1);
        end
        LOAD: if (i_valid) begin
          if (i_sop) begin
            r_cfg_len <= cfg_in_len; r_relu <= cfg_relu;
            r_wcnt <= LEN_W'(1); r_len <= LEN_W'(1);
          end else begin
            r_wcnt <= w_cnt_nxt; r_len <= w_cnt_nxt;
          end
        end
        COMPUTE: r_idx <= (r_idx == r_len - LEN_W'(1)) ? '0 : r_idx + LEN_W'(1);
        OUTPUT: if (o_ready) begin
          if (r_beat == LAST_BEAT) begin
            r_beat <= '0;
            r_pass <= (r_pass == LAST_PASS) ? '0 : r_pass + PASS_W'(1);
          end else begin
            r_beat <= r_beat + LANE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en && i_valid) begin
      if ((r_state == IDLE || r_state == LOAD) && i_sop) r_buf[0] <= i_data;
      else if (r_state == LOAD) r_buf[r_wcnt[IDX_W-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en && w_wr_ok && wr_bias) r_bias[wr_neuron] <= wr_data;
  end

  for (genvar l = 0; l < MAC_LANES; l++) begin : g_lane
    logic [WEIGHT_WIDTH-1:0]        r_bank [DEPTH];
    logic signed [WEIGHT_WIDTH-1:0] r_w;
    logic signed [PROD_W-1:0]       r_prod;
    logic signed [ACC_W-1:0]        r_acc;
    logic signed [PIX_WIDTH-1:0]    r_res;
    logic signed [SUM_W-1:0]        w_sum, w_shr;
    logic signed [PIX_WIDTH-1:0]    w_sat;
    logic [NEU_W-1:0]               w_bidx;

    always_ff @(posedge clk) begin
      if (clk_en && w_wr_ok && !wr_bias && w_wr_lane == 32'(l)) r_bank[w_wr_addr] <= wr_data;
    end

    assign w_bidx = NEU_W'(32'(r_pass) * MAC_LANES + l);
    assign w_sum  = SUM_W'(r_acc) + SUM_W'(r_bias[w_bidx]) + RND;
    assign w_shr  = w_sum >>> WEIGHT_FRACT_WIDTH;

    always_comb begin
      if (w_shr > PMAX)      w_sat = {1'b0, {(PIX_WIDTH-1){1'b1}}};
      else if (w_shr < PMIN) w_sat = {1'b1, {(PIX_WIDTH-1){1'b0}}};
      else                   w_sat = w_shr[PIX_WIDTH-1:0];
      if (r_relu && w_sat[PIX_WIDTH-1]) w_sat = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_w <= '0; r_prod <= '0; r_acc <= '0; r_res <= '0;
      end else if (clk_en) begin
        if (r_state == COMPUTE) r_w <= r_bank[w_rd_addr];
        if (r_v1) r_prod <= PROD_W'(r_x) * PROD_W'(r_w);
        if (r_v2) r_acc  <= (r_f2 ? '0 : r_acc) + ACC_W'(r_prod);
        if (w_post) r_res <= w_sat;
      end
    end

    assign w_obuf[l] = r_res;
  end

endmodule

// File: tb/tb_fc_layer_mac_array.sv
// Directed bench for fc_layer_mac_array with IN=4, OUT=4, LANES=2, FRACT=10.
module tb_fc_layer_mac_array;

  logic        clk = 1'b0;
  logic        rst, clk_en, cfg_relu;
  logic [2:0]  cfg_in_len;
  logic [15:0] i_data, o_data, wr_data;
  logic        i_valid, i_sop, i_eop, i_ready;
  logic        o_valid, o_sop, o_eop, o_ready, o_err;
  logic        wr_en, wr_bias;
  logic [1:0]  wr_neuron, wr_index;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          err_cnt  = 0;
  logic        err_after;
  logic [15:0] vec [4];
  logic [15:0] exp_out [4];

  fc_layer_mac_array #(
    .PIX_WIDTH(16), .WEIGHT_WIDTH(16), .WEIGHT_FRACT_WIDTH(10),
    .IN_DIMENSION(4), .OUT_DIMENSION(4), .MAC_LANES(2)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .cfg_in_len(cfg_in_len), .cfg_relu(cfg_relu),
    .i_data(i_data), .i_valid(i_valid), .i_sop(i_sop), .i_eop(i_eop), .i_ready(i_ready),
    .o_data(o_data), .o_valid(o_valid), .o_sop(o_sop), .o_eop(o_eop), .o_ready(o_ready),
    .o_err(o_err),
    .wr_en(wr_en), .wr_bias(wr_bias), .wr_neuron(wr_neuron), .wr_index(wr_index),
    .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_err === 1'b1) err_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int n, input int idx, input logic b, input logic [15:0] d);
    wr_en = 1'b1; wr_bias = b; wr_neuron = 2'(n); wr_index = 2'(idx); wr_data = d;
    tick();
    wr_en = 1'b0; wr_bias = 1'b0;
  endtask

  task automatic load_w(input logic [15:0] diag, input logic [15:0] off);
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 4; i++) wr(n, i, 1'b0, (n == i) ? diag : off);
  endtask

  task automatic send(input int n, input int cfg_len, input logic relu);
    cfg_in_len = 3'(cfg_len); cfg_relu = relu;
    for (int i = 0; i < n; i++) begin
      i_valid = 1'b1; i_sop = (i == 0); i_eop = (i == n - 1); i_data = vec[i];
      chk("i_ready_load", 32'(i_ready), 32'd1);
      tick();
    end
    i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    err_after = o_err;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!o_valid && cycles < 60) begin tick(); cycles++; end
  endtask

  task automatic recv(input int first);
    int c;
    for (int b = first; b < 4; b++) begin
      wait_valid(c);
      chk("o_valid", 32'(o_valid), 32'd1);
      chk($sformatf("o_data[%0d]", b), 32'(o_data), 32'(exp_out[b]));
      chk($sformatf("o_sop[%0d]", b), 32'(o_sop), 32'(b == 0));
      chk($sformatf("o_eop[%0d]", b), 32'(o_eop), 32'(b == 3));
      tick();
    end
  endtask

  initial begin
    int c, e0;
    rst = 1'b1; clk_en = 1'b1; cfg_relu = 1'b0; cfg_in_len = 3'd4;
    i_data = '0; i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0; o_ready = 1'b1;
    wr_en = 1'b0; wr_bias = 1'b0; wr_neuron = '0; wr_index = '0; wr_data = '0;
    tick(); tick();
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_sop",   32'(o_sop),   32'd0);
    chk("rst_o_eop",   32'(o_eop),   32'd0);
    chk("rst_o_err",   32'(o_err),   32'd0);
    chk("rst_o_data",  32'(o_data),  32'd0);
    chk("rst_i_ready", 32'(i_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Identity
    load_w(16'd1024, 16'd0);
    for (int n = 0; n < 4; n++) wr(n, 0, 1'b1, 16'd0);
    e0 = err_cnt;
    vec = '{16'd1, 16'd2, 16'd3, 16'd4};
    exp_out = '{16'd1, 16'd2, 16'd3, 16'd4};
    send(4, 4, 1'b0);
    chk("id_err_eop", 32'(err_after), 32'd0);
    chk("id_i_ready_compute", 32'(i_ready), 32'd0);
    wait_valid(c);
    chk("id_latency", 32'(c), 32'd8);
    recv(0);
    chk("id_err_count", 32'(err_cnt - e0), 32'd0);

    // Bias, rounding, ReLU
    load_w(16'd512, 16'd512);
    wr(0, 0, 1'b1, 16'hEC00);
    vec = '{16'd1, 16'd1, 16'd1, 16'd0};
    exp_out = '{16'hFFFD, 16'd2, 16'd2, 16'd2};
    send(4, 4, 1'b0);
    recv(0);
    exp_out = '{16'd0, 16'd2, 16'd2, 16'd2};
    send(4, 4, 1'b1);
    recv(0);

    // Saturation
    wr(0, 0, 1'b1, 16'd0);
    load_w(16'd2048, 16'd2048);
    vec = '{16'd32767, 16'd32767, 16'd32767, 16'd32767};
    exp_out = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    send(4, 4, 1'b0);
    recv(0);
    load_w(16'hF800, 16'hF800);
    exp_out = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    send(4, 4, 1'b0);
    recv(0);

    // Backpressure on beat 1
    load_w(16'd1024, 16'd0);
    vec = '{16'd5, 16'd6, 16'd7, 16'd8};
    exp_out = '{16'd5, 16'd6, 16'd7, 16'd8};
    send(4, 4, 1'b0);
    recv(0);
    vec = '{16'd5, 16'd6, 16'd7, 16'd8};
    send(4, 4, 1'b0);
    wait_valid(c);
    chk("bp_beat0", 32'(o_data), 32'd5);
    tick();
    o_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_valid", 32'(o_valid), 32'd1);
      chk("bp_hold_data",  32'(o_data),  32'd6);
    end
    o_ready = 1'b1;
    tick();
    chk("bp_after_accept_valid", 32'(o_valid), 32'd0);
    wait_valid(c);
    chk("bp_pass2_latency", 32'(c), 32'd8);
    recv(2);

    // Short frame, then weight write during OUTPUT
    vec = '{16'd3, 16'd9, 16'd0, 16'd0};
    exp_out = '{16'd3, 16'd9, 16'd0, 16'd0};
    send(2, 4, 1'b0);
    chk("short_err_pulse", 32'(err_after), 32'd1);
    tick();
    chk("short_err_clear", 32'(o_err), 32'd0);
    wait_valid(c);
    chk("short_beat0", 32'(o_data), 32'd3);
    wr(0, 0, 1'b0, 16'd0);
    chk("wr_output_err", 32'(o_err), 32'd1);
    recv(1);

    // Reset mid-COMPUTE
    vec = '{16'd1, 16'd2, 16'd3, 16'd4};
    send(4, 4, 1'b0);
    tick(); tick();
    chk("pre_rst_i_ready", 32'(i_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_o_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_i_ready", 32'(i_ready), 32'd1);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    chk("post_rst_no_partial", 32'(o_valid), 32'd0);
    exp_out = '{16'd1, 16'd2, 16'd3, 16'd4};
    send(4, 4, 1'b0);
    recv(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
